mem_port_arbiter: RTL

- Shares one single-ported memory bus between two requesters of the riscv32b core: the instruction-fetch port (read-only) and the LSU data port (read/write).
- Sequences each access through a small FSM: grant, hold the bus until memory ready, return data or completion.
- Includes a bounded-wait timeout so a dead memory cannot hang the core.
- Sits between the core's instr_*/data_* ports and the SoC memory.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / LSU data) arbiter onto a single memory bus, with a
// bounded-wait timeout. Define ARB_RR_EN for round-robin instead of data priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          err_q, err_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic idle, busy, timed_out, finish, d_pick;

    always_comb begin
        idle      = (state_q == IDLE);
        busy      = !idle;
        // Abort on the TIMEOUT-th consecutive not-ready cycle; m_ready on that cycle still completes.
        timed_out = busy && !m_ready && (cnt_q == CW'(TIMEOUT - 1));
        finish    = (busy && m_ready) || timed_out;
    end

`ifdef ARB_RR_EN
    logic last_i_q, last_i_d;

    always_comb d_pick = d_req && (!i_req || last_i_q);

    always_comb begin
        last_i_d = last_i_q;
        if (i_gnt)
            last_i_d = 1'b1;
        else if (d_gnt)
            last_i_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_i_q <= 1'b0;
        else
            last_i_q <= last_i_d;
    end
`else
    always_comb d_pick = d_req;
`endif

    // Output process
    always_comb begin
        i_gnt   = idle && i_req && !d_pick;
        d_gnt   = idle && d_pick;
        m_req   = busy;
        m_we    = busy && we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        i_done  = i_done_q;
        d_done  = d_done_q;
        err     = err_q;
        i_rdata = i_rdata_q;
        d_rdata = d_rdata_q;
    end

    // Next-state process
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_gnt)
                    state_d = BUSY_D;
                else if (i_gnt)
                    state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (finish)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (d_gnt) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
        end else if (i_gnt) begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
        end
        if (busy)
            cnt_d = finish ? '0 : cnt_q + CW'(1);
        if (finish) begin
            err_d = timed_out;
            if (state_q == BUSY_I) begin
                i_done_d  = 1'b1;
                i_rdata_d = timed_out ? '0 : m_rdata;
            end else begin
                d_done_d  = 1'b1;
                d_rdata_d = (timed_out || we_q) ? '0 : m_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end
endmodule
